// File: rtl/keypad_sequencer_pkg.sv
// keypad_sequencer_pkg: command/key encodings and sequencer states shared by the keypad front-end
package keypad_sequencer_pkg;

    typedef enum logic [1:0] {
        COM_NONE = 2'd0,
        COM_ARM  = 2'd1,
        COM_DIS  = 2'd2
    } command_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PAD     = 2'd2
    } seq_state_e;

    localparam logic [3:0] KEY_ARM = 4'hA;
    localparam logic [3:0] KEY_DIS = 4'hB;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/keypad_sequencer_debouncer.sv
// keypad_sequencer_debouncer: synchronizes and debounces the key line, emitting one event per accepted press
module keypad_sequencer_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_pressed_i,
    input  logic [3:0] key_code_i,
    output logic       key_event_o,
    output logic [3:0] key_code_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          prev_q, event_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    code_q, code_d;
    logic          flip;

    always_comb begin
        flip    = (sync2_q != level_q) && (cnt_q == CW'(DEBOUNCE_CYCLES - 1));
        cnt_d   = (sync2_q == level_q || flip) ? '0 : cnt_q + 1'b1;
        level_d = flip ? sync2_q : level_q;
        code_d  = (flip && sync2_q) ? key_code_i : code_q;
    end

    // The event is taken from the registered level edge, so code_q is settled when it fires
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            event_q <= 1'b0;
            code_q  <= '0;
        end else begin
            sync1_q <= key_pressed_i;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            prev_q  <= level_q;
            event_q <= level_q & ~prev_q;
            code_q  <= code_d;
        end
    end

    assign key_event_o = event_q;
    assign key_code_o  = code_q;

endmodule

// File: rtl/keypad_sequencer.sv
// keypad_sequencer: enforces one ARM/DIS command followed by CODE_LEN digits, padding on entry timeout
module keypad_sequencer
    import keypad_sequencer_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 16,
    parameter int         TIMEOUT_CYCLES  = 1024,
    parameter int         CODE_LEN        = 3,
    parameter logic [3:0] PAD_DIGIT       = 4'hF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_pressed,
    input  logic [3:0] key_code,
    output logic [1:0] command,
    output logic [3:0] digit,
    output logic       digit_entered,
    output logic       busy,
    output logic       timeout
);

    localparam int          TW   = $clog2(TIMEOUT_CYCLES);
    localparam int          NW   = $clog2(CODE_LEN + 1);
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

    logic          key_event;
    logic [3:0]    key_code_q;
    seq_state_e    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [NW-1:0] cnt_q, cnt_d;
    command_e      command_q, command_d;
    logic [3:0]    digit_q, digit_d;
    logic          strobe_q, strobe_d;
    logic          busy_q, busy_d;
    logic          timeout_q, timeout_d;
    logic          last;

    keypad_sequencer_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .clk          (clk),
        .reset        (reset),
        .key_pressed_i(key_pressed),
        .key_code_i   (key_code),
        .key_event_o  (key_event),
        .key_code_o   (key_code_q)
    );

    always_comb begin
        state_d   = state_q;
        timer_d   = '0;
        cnt_d     = cnt_q;
        command_d = COM_NONE;
        digit_d   = digit_q;
        strobe_d  = 1'b0;
        timeout_d = 1'b0;
        last      = cnt_q == NW'(CODE_LEN - 1);
        case (state_q)
            ST_IDLE: begin
                if (key_event && (key_code_q == KEY_ARM || key_code_q == KEY_DIS)) begin
                    command_d = key_code_q == KEY_ARM ? COM_ARM : COM_DIS;
                    cnt_d     = '0;
                    state_d   = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                timer_d = timer_q == TMAX ? timer_q : timer_q + 1'b1;
                // A typed digit on the expiry cycle takes priority over padding
                if (key_event && is_digit(key_code_q)) begin
                    digit_d  = key_code_q;
                    strobe_d = 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    timer_d  = '0;
                    state_d  = last ? ST_IDLE : ST_COLLECT;
                end else if (timer_q == TMAX) begin
                    digit_d   = PAD_DIGIT;
                    strobe_d  = 1'b1;
                    timeout_d = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                    state_d   = last ? ST_IDLE : ST_PAD;
                end
            end
            ST_PAD: begin
                digit_d  = PAD_DIGIT;
                strobe_d = 1'b1;
                cnt_d    = cnt_q + 1'b1;
                state_d  = last ? ST_IDLE : ST_PAD;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = state_d != ST_IDLE || strobe_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            timer_q   <= '0;
            cnt_q     <= '0;
            command_q <= COM_NONE;
            digit_q   <= '0;
            strobe_q  <= 1'b0;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            cnt_q     <= cnt_d;
            command_q <= command_d;
            digit_q   <= digit_d;
            strobe_q  <= strobe_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
        end
    end

    assign command       = command_q;
    assign digit         = digit_q;
    assign digit_entered = strobe_q;
    assign busy          = busy_q;
    assign timeout       = timeout_q;

endmodule
